// File: rtl/uart_rx_byte_fifo_pkg.sv
// Shared defaults and helpers for the UART receive byte FIFO.
// Sizes the storage and the saturating drop counter.
package uart_rx_byte_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

    // The drop counter saturates so a long overrun never wraps back to a small count.
    function automatic logic [7:0] drop_cnt_inc(input logic [7:0] cnt);
        return (cnt == DROP_CNT_MAX) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read with read enable.
// The read register is reset so the popped-byte output starts at zero.
module uart_fifo_mem
    import uart_rx_byte_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write on a shared address: a pop at Full sees the old byte.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_rx_byte_fifo.sv
// Buffers bytes from the UART receive controller and hands them to host logic
// through a registered read-request/valid handshake, with overflow accounting.
module uart_rx_byte_fifo
    import uart_rx_byte_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              RX_Done_Sig,
    input  logic [DATA_W-1:0] RX_Data,
    input  logic              Rd_Req,
    input  logic              Ovf_Clr,
    output logic [DATA_W-1:0] Rd_Data,
    output logic              Rd_Valid,
    output logic              Empty,
    output logic              Full,
    output logic [ADDR_W:0]   Level,
    output logic              Overflow,
    output logic [7:0]        Drop_Cnt
);

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(1 << ADDR_W);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_rd_valid;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_rd_data;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LEVEL_FULL);

    // A pop in the same cycle frees a slot, so a write at Full is still accepted.
    assign w_pop  = Rd_Req && !w_empty;
    assign w_push = RX_Done_Sig && (!w_full || w_pop);
    assign w_drop = RX_Done_Sig && w_full && !w_pop;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (RX_Data),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= Ovf_Clr ? 8'd1 : drop_cnt_inc(r_drop_cnt);
        end else if (Ovf_Clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end
    end

    assign Rd_Data  = w_rd_data;
    assign Rd_Valid = r_rd_valid;
    assign Empty    = w_empty;
    assign Full     = w_full;
    assign Level    = r_level;
    assign Overflow = r_overflow;
    assign Drop_Cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Directed bench for uart_rx_byte_fifo: stimulus queues expected bytes,
// a negedge monitor pops and compares them whenever Rd_Valid is seen.
module tb_uart_rx_byte_fifo;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       RX_Done_Sig = 1'b0;
    logic [7:0] RX_Data = 8'h00;
    logic       Rd_Req = 1'b0;
    logic       Ovf_Clr = 1'b0;
    logic [7:0] Rd_Data;
    logic       Rd_Valid;
    logic       Empty;
    logic       Full;
    logic [4:0] Level;
    logic       Overflow;
    logic [7:0] Drop_Cnt;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_byte = 8'h00;

    always #5 CLK = ~CLK;

    uart_rx_byte_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .RX_Done_Sig (RX_Done_Sig),
        .RX_Data     (RX_Data),
        .Rd_Req      (Rd_Req),
        .Ovf_Clr     (Ovf_Clr),
        .Rd_Data     (Rd_Data),
        .Rd_Valid    (Rd_Valid),
        .Empty       (Empty),
        .Full        (Full),
        .Level       (Level),
        .Overflow    (Overflow),
        .Drop_Cnt    (Drop_Cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTn && Rd_Valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rd_valid", 32'(Rd_Data), 32'hDEAD);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                check("rd_data", 32'(Rd_Data), 32'(e));
                $display("pop: Rd_Data=%02h expected=%02h", Rd_Data, e);
                last_byte = Rd_Data;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input bit accepted);
        RX_Done_Sig = 1'b1;
        RX_Data     = d;
        if (accepted) sb_q.push_back(d);
        tick();
        RX_Done_Sig = 1'b0;
        $display("write: RX_Data=%02h accepted=%0d Level=%0d", d, accepted, Level);
    endtask

    task automatic pop_one();
        Rd_Req = 1'b1;
        tick();
        Rd_Req = 1'b0;
        check("pop_valid", 32'(Rd_Valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"},    32'(Level),    32'd0);
        check({tag, "_empty"},    32'(Empty),    32'd1);
        check({tag, "_full"},     32'(Full),     32'd0);
        check({tag, "_rd_valid"}, 32'(Rd_Valid), 32'd0);
        check({tag, "_rd_data"},  32'(Rd_Data),  32'd0);
        check({tag, "_overflow"}, 32'(Overflow), 32'd0);
        check({tag, "_drop_cnt"}, 32'(Drop_Cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) tick();
        check_reset_outputs("reset");
        RSTn = 1'b1;
        tick();

        // Single byte round trip
        write_byte(8'hA5, 1);
        check("t1_level1", 32'(Level), 32'd1);
        check("t1_empty0", 32'(Empty), 32'd0);
        pop_one();
        check("t1_level0", 32'(Level), 32'd0);
        check("t1_empty1", 32'(Empty), 32'd1);
        tick();
        check("t1_valid_drop", 32'(Rd_Valid), 32'd0);

        // Fill 16, drain back-to-back
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1);
        check("t2_full", 32'(Full), 32'd1);
        check("t2_level16", 32'(Level), 32'd16);
        Rd_Req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t2_valid_b2b", 32'(Rd_Valid), 32'd1);
        end
        Rd_Req = 1'b0;
        check("t2_empty", 32'(Empty), 32'd1);
        tick();
        check("t2_valid_end", 32'(Rd_Valid), 32'd0);

        // Overflow at Full, then clear
        for (int i = 0; i < 16; i++) write_byte(8'h10 + 8'(i), 1);
        for (int i = 0; i < 3; i++) write_byte(8'hE0 + 8'(i), 0);
        check("t3_overflow", 32'(Overflow), 32'd1);
        check("t3_drop_cnt", 32'(Drop_Cnt), 32'd3);
        check("t3_level16", 32'(Level), 32'd16);
        Ovf_Clr = 1'b1;
        tick();
        Ovf_Clr = 1'b0;
        check("t3_ovf_clr", 32'(Overflow), 32'd0);
        check("t3_drop_clr", 32'(Drop_Cnt), 32'd0);

        // Drop and clear in the same cycle: drop wins
        write_byte(8'hE3, 0);
        write_byte(8'hE4, 0);
        Ovf_Clr = 1'b1;
        write_byte(8'hE5, 0);
        Ovf_Clr = 1'b0;
        check("t3b_overflow", 32'(Overflow), 32'd1);
        check("t3b_drop_cnt", 32'(Drop_Cnt), 32'd1);
        Ovf_Clr = 1'b1;
        tick();
        Ovf_Clr = 1'b0;
        check("t3b_cleared", 32'(Overflow), 32'd0);

        // Simultaneous write and pop at Full
        Rd_Req = 1'b1;
        write_byte(8'h5A, 1);
        Rd_Req = 1'b0;
        check("t4_valid", 32'(Rd_Valid), 32'd1);
        check("t4_overflow", 32'(Overflow), 32'd0);
        check("t4_level16", 32'(Level), 32'd16);
        for (int i = 0; i < 16; i++) pop_one();
        #5;
        check("t4_last_5a", 32'(last_byte), 32'h5A);
        check("t4_empty", 32'(Empty), 32'd1);
        tick();

        // Write and read on empty: no bypass
        Rd_Req = 1'b1;
        write_byte(8'h33, 1);
        Rd_Req = 1'b0;
        check("t5_no_bypass", 32'(Rd_Valid), 32'd0);
        check("t5_level1", 32'(Level), 32'd1);
        pop_one();
        tick();

        // Interleave 20 bytes across pointer wrap
        write_byte(8'h40, 1);
        for (int i = 1; i < 20; i++) begin
            Rd_Req = 1'b1;
            write_byte(8'h40 + 8'(i), 1);
            Rd_Req = 1'b0;
            check("t6_level_hold", 32'(Level), 32'd1);
        end
        pop_one();
        tick();
        for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i), 1);
        check("t6_level5", 32'(Level), 32'd5);

        // Asynchronous reset mid-cycle
        #2;
        RSTn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb_q.delete();
        tick();
        RSTn = 1'b1;
        tick();
        write_byte(8'h77, 1);
        check("t7_level1", 32'(Level), 32'd1);
        pop_one();
        tick();
        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
